// File: rtl/button_conditioner.sv
// Three-button front end: 2-flop sync, counter debounce, rising-edge pulse, then arbitration.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the left/right direction buttons.

module button_conditioner_lane #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic rise
);
  logic             sync1, sync2, db_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2 == db) cnt <= '0;
      else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        db  <= sync2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end

  assign rise = db & ~db_prev;
endmodule

`ifdef AUTO_REPEAT_EN
module button_conditioner_rep #(
  parameter int REPEAT_DELAY  = 10,
  parameter int REPEAT_PERIOD = 5,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic db,
  input  logic rise,
  input  logic clr,
  output logic rep
);
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = ((state == DELAY)  && (cnt == CNT_W'(REPEAT_DELAY - 1))) ||
                  ((state == REPEAT) && (cnt == CNT_W'(REPEAT_PERIOD - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE || state == IDLE || expire) cnt <= '0;
      else cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!db || clr) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (rise) state_nxt = DELAY;
        DELAY:   if (expire) state_nxt = REPEAT;
        REPEAT:  state_nxt = REPEAT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    rep = expire & db & ~clr;
  end
endmodule
`endif

module button_conditioner #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_reset,
  output logic       go_left,
  output logic       go_right,
  output logic       srst,
  output logic [2:0] held
);
  localparam int MAX_DR  = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int MAX_P   = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_P) + 1;
  localparam int NUM_BTN = 3;

  logic [NUM_BTN-1:0] btn_v, db_v, rise_v;
  logic [1:0]         rep;
  logic               pl, pr, ps;

  assign btn_v = {btn_reset, btn_right, btn_left};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    button_conditioner_lane #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_v[i]),
      .db   (db_v[i]),
      .rise (rise_v[i])
    );
  end

  assign held = db_v;
  assign ps   = rise_v[2];

`ifdef AUTO_REPEAT_EN
  logic clr;
  // Holding both directions or a sequence reset kills any pending repeat.
  assign clr = ps | (db_v[0] & db_v[1]);
  for (genvar d = 0; d < 2; d++) begin : g_rep
    button_conditioner_rep #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_rep (
      .clk  (clk),
      .rst_n(rst_n),
      .db   (db_v[d]),
      .rise (rise_v[d]),
      .clr  (clr),
      .rep  (rep[d])
    );
  end
`else
  assign rep = 2'b00;
`endif

  assign pl = rise_v[0] | rep[0];
  assign pr = rise_v[1] | rep[1];

  // srst wins over directions; simultaneous left+right cancel each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_left  <= 1'b0;
      go_right <= 1'b0;
      srst     <= 1'b0;
    end else begin
      go_left  <= pl & ~pr & ~ps;
      go_right <= pr & ~pl & ~ps;
      srst     <= ps;
    end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: event-level reference model feeds an expected-pulse
// queue, an independent negedge monitor pops it. Honours AUTO_REPEAT_EN like the design.

module tb_button_conditioner;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_reset = 1'b0;
  logic       go_left, go_right, srst;
  logic [2:0] held;

  button_conditioner #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_reset(btn_reset),
    .go_left  (go_left),
    .go_right (go_right),
    .srst     (srst),
    .held     (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edg;
    logic [2:0] code;  // {srst, go_right, go_left}
  } ev_t;

  ev_t        expq[$];
  logic [2:0] hist[$];      // per-edge raw samples since reset release
  logic [2:0] mdb = 3'b000; // model debounced levels
  int         cur_edge = -1;
`ifdef AUTO_REPEAT_EN
  logic [1:0] act = 2'b00;
  int         start_e [2];
`endif
  int chk = 0, err = 0;
  int seen_l = 0, seen_r = 0, seen_s = 0;
  int last_l = -1, last_r = -1, last_s = -1;

  task automatic model_reset();
    expq.delete();
    hist.delete();
    mdb      = 3'b000;
    cur_edge = -1;
`ifdef AUTO_REPEAT_EN
    act = 2'b00;
`endif
  endtask

  // A level is accepted once the synchronised input (raw delayed two edges) has shown it
  // for DB consecutive edges while differing from the accepted level.
  task automatic model_edge(input logic [2:0] s);
    logic [2:0] old_db, rise, p, exp_code;
    logic [1:0] rep;
    logic       v, all_same, both;
    int         n;
    cur_edge++;
    hist.push_back(s);
    n      = hist.size();
    old_db = mdb;
    for (int b = 0; b < 3; b++) begin
      if (n >= DB + 2) begin
        v        = hist[n-3][b];
        all_same = 1'b1;
        for (int j = 0; j < DB; j++) if (hist[n-3-j][b] != v) all_same = 1'b0;
        if (all_same && mdb[b] != v) mdb[b] = v;
      end
    end
    rise = mdb & ~old_db;
    both = mdb[0] & mdb[1];
    rep  = 2'b00;
`ifdef AUTO_REPEAT_EN
    for (int d = 0; d < 2; d++) begin
      if (rise[d]) begin
        act[d]     = !(both || rise[2]);
        start_e[d] = cur_edge;
      end else if (act[d]) begin
        if (!mdb[d] || both || rise[2]) act[d] = 1'b0;
        else if ((cur_edge - start_e[d]) >= RD && ((cur_edge - start_e[d] - RD) % RP) == 0)
          rep[d] = 1'b1;
      end
    end
`endif
    p        = rise | {1'b0, rep};
    exp_code = {p[2], p[1] & ~p[0] & ~p[2], p[0] & ~p[1] & ~p[2]};
    if (exp_code != 3'b000) expq.push_back('{edg: cur_edge + 1, code: exp_code});
  endtask

  task automatic step(input logic [2:0] s);
    {btn_reset, btn_right, btn_left} = s;
    @(posedge clk);
    model_edge(s);
    @(negedge clk);
  endtask

  task automatic expect_eq(input string name, input int got, input int req);
    chk++;
    if (got != req) begin
      err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Called at a negedge; drops reset between edges and checks the asynchronous clear.
  task automatic async_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    chk++;
    if ({go_left, go_right, srst, held} !== 6'b0) begin
      err++;
      $display("FAIL reset_outputs: got %b, required 000000", {go_left, go_right, srst, held});
    end
    model_reset();
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every pulse the DUT presents must match the head of the expected queue.
  initial begin
    logic [2:0] got;
    ev_t        ev;
    forever begin
      @(negedge clk);
      if (rst_n && cur_edge >= 0) begin
        got = {srst, go_right, go_left};
        while (expq.size() > 0 && expq[0].edg < cur_edge) begin
          chk++;
          err++;
          $display("FAIL missed_pulse edge %0d: got 000, required %b", expq[0].edg, expq[0].code);
          void'(expq.pop_front());
        end
        if (got != 3'b000) begin
          if (got[0]) begin seen_l++; last_l = cur_edge; end
          if (got[1]) begin seen_r++; last_r = cur_edge; end
          if (got[2]) begin seen_s++; last_s = cur_edge; end
          chk++;
          if (expq.size() == 0 || expq[0].edg != cur_edge) begin
            err++;
            $display("FAIL unexpected_pulse edge %0d: got %b, required 000", cur_edge, got);
          end else begin
            ev = expq.pop_front();
            if (ev.code !== got) begin
              err++;
              $display("FAIL pulse_code edge %0d: got %b, required %b", cur_edge, got, ev.code);
            end
          end
        end
        chk++;
        if (held !== mdb) begin
          err++;
          $display("FAIL held edge %0d: got %b, required %b", cur_edge, held, mdb);
        end
      end
    end
  end

  initial begin
    int         b0, b1, b2;
    int         rem [3];
    logic [2:0] lvl;
    rem = '{0, 0, 0};
    lvl = 3'b000;

    async_reset(2);

    // Short bounce never accepted.
    async_reset(2);
    b0 = seen_l;
    repeat (3) step(3'b001);
    repeat (15) step(3'b000);
    #1 expect_eq("t1_no_go_left", seen_l - b0, 0);

    // Single clean press: pulse lands after edge DB+2.
    async_reset(2);
    b0 = seen_l;
    repeat (20) step(3'b001);
    repeat (15) step(3'b000);
    #1 expect_eq("t2_go_left_count", seen_l - b0, 1);
    expect_eq("t2_go_left_edge", last_l, 6);

    // Long right press: auto-repeat cadence when enabled.
    async_reset(2);
    b0 = seen_r;
    repeat (25) step(3'b010);
    repeat (20) step(3'b000);
`ifdef AUTO_REPEAT_EN
    #1 expect_eq("t3_go_right_count", seen_r - b0, 4);
    expect_eq("t3_go_right_last", last_r, 26);
`else
    #1 expect_eq("t3_go_right_count", seen_r - b0, 1);
    expect_eq("t3_go_right_last", last_r, 6);
`endif

    // Both directions together cancel.
    async_reset(2);
    b0 = seen_l; b1 = seen_r;
    repeat (20) step(3'b011);
    repeat (15) step(3'b000);
    #1 expect_eq("t4_no_go", (seen_l - b0) + (seen_r - b1), 0);

    // Bouncing reset button, then steady.
    async_reset(2);
    b0 = seen_l; b1 = seen_r; b2 = seen_s;
    for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 3'b100 : 3'b000);
    repeat (15) step(3'b100);
    repeat (15) step(3'b000);
    #1 expect_eq("t5_srst_count", seen_s - b2, 1);
    expect_eq("t5_srst_edge", last_s, 26);
    expect_eq("t5_no_go", (seen_l - b0) + (seen_r - b1), 0);

    // Reset mid-press discards progress; button still held afterwards.
    async_reset(2);
    repeat (3) step(3'b001);
    async_reset(2);
    b0 = seen_l;
    repeat (15) step(3'b001);
    repeat (15) step(3'b000);
    #1 expect_eq("t6_go_left_count", seen_l - b0, 1);
    expect_eq("t6_go_left_edge", last_l, 6);

    // Second direction pressed while first held gets its own pulse.
    async_reset(2);
    b0 = seen_l; b1 = seen_r;
    repeat (10) step(3'b001);
    repeat (15) step(3'b011);
    repeat (15) step(3'b000);
    #1 expect_eq("t7_go_left_count", seen_l - b0, 1);
    expect_eq("t7_go_right_count", seen_r - b1, 1);

    // Random bouncing on all three buttons with one reset in the middle.
    async_reset(2);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = (b == 2) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
          rem[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 40));
        end
      end
      step(lvl);
      for (int b = 0; b < 3; b++) rem[b]--;
      if (c == 1500) async_reset(3);
    end
    repeat (60) step(3'b000);
    #1 expect_eq("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
